vga_scan_ctrl: RTL
==================

# vga_scan_ctrl

Scan-side controller for the VGA logo painters. It generates the 800x600@72 Hz raster from a 50 MHz pixel clock and drives the `x`, `y` and `delt` buses that the logo painters consume. It takes back their OR-ed `hit` and produces registered, sync-aligned pixel colour plus `hsync`/`vsync`. It also owns the per-frame animation offset `delt`, which bounces between 0 and a maximum.

## Interface
Parameters:
- `H_VISIBLE` 800; `H_FRONT` 56; `H_SYNC` 120; `H_BACK` 64 (H total 1040)
- `V_VISIBLE` 600; `V_FRONT` 37; `V_SYNC` 6; `V_BACK` 23 (V total 666)
- `DELT_MAX` 200 — upper bound of `delt`
- `DELT_STEP` 1 — `delt` change per update
- `FRAME_DIV` 1 — frames per `delt` update (≥1)

Ports:
- `clk` in 1 — pixel clock, 50 MHz
- `rst` in 1 — reset, asynchronous, active-high
- `enable` in 1 — animation enable; scanning always runs
- `hit` in 1 — combinational painter result for the current `x`,`y`
- `fg_color` in 9 — RGB333 colour when `hit`
- `bg_color` in 9 — RGB333 colour when not `hit`
- `x` out 11 — current column counter, 0..1039
- `y` out 11 — current line counter, 0..665
- `delt` out 11 — animation offset
- `rgb` out 9 — registered pixel colour
- `hsync` out 1 — registered, positive polarity
- `vsync` out 1 — registered, positive polarity
- `video_on` out 1 — registered visible-area flag
- `frame_start` out 1 — one-cycle pulse, registered

## Operation
- `x` increments every cycle. At 1039 it wraps to 0 and `y` increments; `y` wraps from 665 to 0.
- Visible area is `x`<800 and `y`<600.
- Sync windows:
  - H sync active for `x` in 856..975.
  - V sync active for `y` in 637..642.
- Output stage registers values from the current `x`,`y`,`hit`:
  - `rgb` = visible ? (`hit` ? `fg_color` : `bg_color`) : 0.
  - `hsync`, `vsync` and `video_on` are registered from the same cycle.
- `frame_start` is asserted in the cycle after `x`=0,`y`=0 is presented.
- Frame end is the cycle with `x`=1039 and `y`=665.
  - At frame end with `enable`=1, the frame divider increments.
  - When the divider reaches `FRAME_DIV`-1, it clears and `delt` updates.
- `delt` FSM, states UP and DOWN:
  - UP: `delt` ← min(`delt`+`DELT_STEP`, `DELT_MAX`). If the result equals `DELT_MAX`, go to DOWN.
  - DOWN: `delt` ← `delt`≥`DELT_STEP` ? `delt`−`DELT_STEP` : 0. If the result is 0, go to UP.
  - Compare in 12 bits to avoid overflow.
- `enable`=0 freezes the divider, `delt` and the FSM. Scan and output continue.
- `delt` changes only at frame end, so painters never see a mid-frame jump.

## Timing
- Reset values:
  - `x`, `y`, `delt`, divider = 0; FSM = UP.
  - `rgb`, `hsync`, `vsync`, `video_on`, `frame_start` = 0.
- `hit` must settle within the same cycle as `x`/`y`, since painters are combinational.
- Output latency is 1 cycle from `x`/`y`. `rgb`, the syncs and `video_on` stay mutually aligned.
- Reset asserted mid-frame returns everything to reset values immediately. The first post-reset `x`=0,`y`=0 frame restarts cleanly, with no partial sync pulse.
- `enable` toggling at frame end: the value sampled in the frame-end cycle decides whether that update happens.

## Structure
- Shared header `vga_defs.vh`:
  - H/V timing constants, totals and sync start/end positions.
  - RGB333 width.
  - FSM state encodings UP=0, DOWN=1.
- Sub-module `delt_animator` holds the divider, the UP/DOWN FSM and `delt`. Its inputs are `clk`, `rst`, `frame_end` and `enable`.
- The top holds the counters, decode and output registers.

## Test plan
- Reset, then release. `x` counts 0,1,2…; `y`=0; all outputs 0.
  - At `x`=1039→0, `y` becomes 1.
  - After 1040×666 cycles, `x`=`y`=0 again and `frame_start` pulses once.
- Sync windows:
  - `hsync`=1 exactly in the cycles after `x`=856..975 (120 cycles per line).
  - `vsync`=1 for lines 637..642 (6×1040 cycles).
- Colour select:
  - `hit`=1, `fg_color`=9'h1C0 at `x`=5,`y`=5 → `rgb`=9'h1C0 next cycle.
  - `hit`=0, `bg_color`=9'h007 → `rgb`=9'h007 next cycle.
  - At `x`=900 with `hit`=1 → `rgb`=0.
- Bounce with `DELT_MAX`=3, `DELT_STEP`=2, `FRAME_DIV`=1, `enable`=1: `delt` across frames is 0,2,3,1,0,2.
- `FRAME_DIV`=2: `delt` changes every second frame end only.
  - `enable`=0 for 3 frames → `delt` and FSM hold.
  - Re-enable → the sequence continues where it left off.
- Assert `rst` at `x`=400,`y`=300 while `delt`=5 in DOWN. All outputs return to 0 immediately and FSM = UP.
  - After release, `delt` rises 0,1,2 on successive frame ends.

Source files
------------

// File: rtl/vga_scan_ctrl_pkg.sv
// Shared definitions for the VGA scan controller.
// Holds the default 800x600@72 Hz raster timing, derived totals and sync
// positions, the RGB333 width, the counter width and the delt FSM encoding.
package vga_scan_ctrl_pkg;

  localparam int CNT_W = 11;
  localparam int RGB_W = 9;

  localparam int H_VISIBLE_D = 800;
  localparam int H_FRONT_D   = 56;
  localparam int H_SYNC_D    = 120;
  localparam int H_BACK_D    = 64;
  localparam int V_VISIBLE_D = 600;
  localparam int V_FRONT_D   = 37;
  localparam int V_SYNC_D    = 6;
  localparam int V_BACK_D    = 23;

  localparam int H_TOTAL_D      = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D      = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
  localparam int H_SYNC_FIRST_D = H_VISIBLE_D + H_FRONT_D;
  localparam int H_SYNC_LAST_D  = H_SYNC_FIRST_D + H_SYNC_D - 1;
  localparam int V_SYNC_FIRST_D = V_VISIBLE_D + V_FRONT_D;
  localparam int V_SYNC_LAST_D  = V_SYNC_FIRST_D + V_SYNC_D - 1;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } delt_state_e;

  // First counter value inside a sync window.
  function automatic int sync_first(input int visible, input int front);
    return visible + front;
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_delt_animator.sv
// delt_animator: per-frame animation offset that bounces between 0 and
// DELT_MAX. A frame divider counts enabled frame ends; every FRAME_DIV of
// them the UP/DOWN FSM moves delt by DELT_STEP.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   frame_end  - high for the last pixel cycle of a frame
//   enable     - animation enable, sampled in the frame-end cycle
//   delt       - current offset (changes only on a frame-end edge)
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_UP   | delt increases, saturating at DELT_MAX; at max -> DOWN
// ST_DOWN | delt decreases, flooring at 0; at 0 -> UP
module delt_animator
  import vga_scan_ctrl_pkg::*;
#(
  parameter int DELT_MAX  = 200,
  parameter int DELT_STEP = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_end,
  input  logic             enable,
  output logic [CNT_W-1:0] delt
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  // 12-bit arithmetic so delt + step cannot wrap before the saturation test.
  localparam logic [11:0] MAX12  = 12'(DELT_MAX);
  localparam logic [11:0] STEP12 = 12'(DELT_STEP);

  delt_state_e      state_q, state_nxt;
  logic [CNT_W-1:0] delt_q, delt_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [11:0]      delt12, up_sum, up_val, dn_val;
  logic             tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UP;
      delt_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_nxt;
      delt_q  <= delt_nxt;
      div_q   <= div_nxt;
    end
  end

  always_comb begin
    tick      = 1'b0;
    div_nxt   = div_q;
    state_nxt = state_q;
    delt_nxt  = delt_q;
    delt12    = {1'b0, delt_q};
    up_sum    = delt12 + STEP12;
    up_val    = (up_sum > MAX12) ? MAX12 : up_sum;
    dn_val    = (delt12 >= STEP12) ? (delt12 - STEP12) : 12'd0;

    if (frame_end && enable) begin
      if (div_q == DIV_LAST) begin
        div_nxt = '0;
        tick    = 1'b1;
      end else begin
        div_nxt = div_q + 1'b1;
      end
    end

    if (tick) begin
      case (state_q)
        ST_UP: begin
          delt_nxt = up_val[CNT_W-1:0];
          if (up_val == MAX12) state_nxt = ST_DOWN;
        end
        ST_DOWN: begin
          delt_nxt = dn_val[CNT_W-1:0];
          if (dn_val == 12'd0) state_nxt = ST_UP;
        end
        default: state_nxt = ST_UP;
      endcase
    end
  end

  always_comb begin
    delt = delt_q;
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster scan generator and output stage for the logo
// painters. Drives x/y/delt to the combinational painters, takes back their
// OR-ed hit and registers rgb, hsync, vsync, video_on and frame_start so all
// outputs are mutually aligned one cycle after the x/y they describe.
// Ports:
//   clk, rst            - pixel clock, asynchronous active-high reset
//   enable              - animation enable (scanning always runs)
//   hit                 - painter result for the current x/y
//   fg_color, bg_color  - RGB333 colours for hit / no hit
//   x, y                - current column / line counters
//   delt                - animation offset, constant within a frame
//   rgb                 - registered pixel colour, 0 outside visible area
//   hsync, vsync        - registered syncs, positive polarity
//   video_on            - registered visible-area flag
//   frame_start         - one-cycle pulse after x=0,y=0 is presented
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_D,
  parameter int H_FRONT   = H_FRONT_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BACK    = H_BACK_D,
  parameter int V_VISIBLE = V_VISIBLE_D,
  parameter int V_FRONT   = V_FRONT_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BACK    = V_BACK_D,
  parameter int DELT_MAX  = 200,
  parameter int DELT_STEP = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             hit,
  input  logic [RGB_W-1:0] fg_color,
  input  logic [RGB_W-1:0] bg_color,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [CNT_W-1:0] delt,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = sync_first(H_VISIBLE, H_FRONT);
  localparam int VS_FIRST = sync_first(V_VISIBLE, V_FRONT);

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(HS_FIRST);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(HS_FIRST + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(VS_FIRST);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(VS_FIRST + V_SYNC - 1);

  logic x_last, y_last, frame_end;
  logic visible, hs_win, vs_win, origin;

  always_comb begin
    x_last    = (x == X_LAST);
    y_last    = (y == Y_LAST);
    frame_end = x_last && y_last;
    visible   = (x < X_VIS) && (y < Y_VIS);
    hs_win    = (x >= HS_LO) && (x <= HS_HI);
    vs_win    = (y >= VS_LO) && (y <= VS_HI);
    origin    = (x == '0) && (y == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // All outputs are taken from the same x/y/hit cycle so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb         <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= visible ? (hit ? fg_color : bg_color) : '0;
      hsync       <= hs_win;
      vsync       <= vs_win;
      video_on    <= visible;
      frame_start <= origin;
    end
  end

  delt_animator #(
    .DELT_MAX (DELT_MAX),
    .DELT_STEP(DELT_STEP),
    .FRAME_DIV(FRAME_DIV)
  ) u_delt (
    .clk      (clk),
    .rst      (rst),
    .frame_end(frame_end),
    .enable   (enable),
    .delt     (delt)
  );

endmodule
